// File: rtl/muldiv_ex.sv
// muldiv_ex: EX-stage multiply/divide unit owning the architectural HI/LO pair.
// A start-class op latches its full 64-bit result up front. A down-counter then
// models the fixed latency, and HI/LO are committed on the last busy edge.
module muldiv_ex #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_Ex,
    input  logic [31:0] Instr_ID,
    input  logic [31:0] rsdata,
    input  logic [31:0] rtdata,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    typedef struct packed {
        logic mult;
        logic multu;
        logic div;
        logic divu;
        logic mfhi;
        logic mthi;
        logic mflo;
        logic mtlo;
    } md_dec_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

    // Only SPECIAL-opcode words carry HI/LO-class functs; everything else is a no-op here.
    function automatic md_dec_t decode(input logic [31:0] ins);
        md_dec_t d;
        d = '0;
        if (ins[31:26] == 6'd0) begin
            case (ins[5:0])
                6'h18:   d.mult  = 1'b1;
                6'h19:   d.multu = 1'b1;
                6'h1A:   d.div   = 1'b1;
                6'h1B:   d.divu  = 1'b1;
                6'h10:   d.mfhi  = 1'b1;
                6'h11:   d.mthi  = 1'b1;
                6'h12:   d.mflo  = 1'b1;
                6'h13:   d.mtlo  = 1'b1;
                default: d = '0;
            endcase
        end
        return d;
    endfunction

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic [31:0] hi_q, lo_q;
    logic [31:0] hi_n, lo_n;     // pending result, committed when the count expires
    logic        wr_n;           // pending result is real (cleared for divide by zero)

    md_dec_t     dec_ex, dec_id;
    logic        is_start, is_div, start, id_md;

    logic [63:0] prod_s, prod_u;
    logic [31:0] dvd_mag, dvs_mag, dvs_safe, q_mag, r_mag;
    logic [63:0] res;
    logic        res_wr;
    logic [3:0]  res_cnt;

    assign dec_ex   = decode(Instr_Ex);
    assign dec_id   = decode(Instr_ID);
    assign is_div   = dec_ex.div | dec_ex.divu;
    assign is_start = dec_ex.mult | dec_ex.multu | is_div;
    assign busy     = (state == S_RUN);
    assign start    = is_start & ~busy;
    assign id_md    = |dec_id;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Result datapath: signed divide runs on magnitudes so INT_MIN / -1 needs no special case.
    always_comb begin
        prod_s   = $signed({{32{rsdata[31]}}, rsdata}) * $signed({{32{rtdata[31]}}, rtdata});
        prod_u   = {32'd0, rsdata} * {32'd0, rtdata};
        dvd_mag  = (dec_ex.div && rsdata[31]) ? -rsdata : rsdata;
        dvs_mag  = (dec_ex.div && rtdata[31]) ? -rtdata : rtdata;
        dvs_safe = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
        q_mag    = dvd_mag / dvs_safe;
        r_mag    = dvd_mag % dvs_safe;
        res      = '0;
        res_wr   = 1'b1;
        res_cnt  = MULT_LD;
        if (dec_ex.mult) begin
            res = prod_s;
        end else if (dec_ex.multu) begin
            res = prod_u;
        end else if (is_div) begin
            res_cnt = DIV_LD;
            res_wr  = (rtdata != 32'd0);
            if (dec_ex.div) begin
                res[31:0]  = (rsdata[31] ^ rtdata[31]) ? -q_mag : q_mag;
                res[63:32] = rsdata[31] ? -r_mag : r_mag;
            end else begin
                res = {r_mag, q_mag};
            end
        end
    end

    // Next state: leave IDLE on an accepted start, return when the count hits one.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN:   if (cnt == 4'd1) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            hi_n  <= '0;
            lo_n  <= '0;
            wr_n  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt  <= res_cnt;
                        hi_n <= res[63:32];
                        lo_n <= res[31:0];
                        wr_n <= res_wr;
                    end else begin
                        if (dec_ex.mthi) hi_q <= rsdata;
                        if (dec_ex.mtlo) lo_q <= rsdata;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1 && wr_n) begin
                        hi_q <= hi_n;
                        lo_q <= lo_n;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Outputs: register read-back for MFHI/MFLO and the stall request for ID.
    always_comb begin
        md_rdata = 32'd0;
        if (dec_ex.mfhi)      md_rdata = hi_q;
        else if (dec_ex.mflo) md_rdata = lo_q;
        stall_md = id_md & (busy | start);
    end

endmodule

// File: tb/tb_muldiv_ex.sv
// tb_muldiv_ex: directed corner cases plus random traffic against an
// arithmetic reference model; a monitor pops expected results from queues.
module tb_muldiv_ex;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_Ex, Instr_ID, rsdata, rtdata;
    logic        busy, stall_md;
    logic [31:0] md_rdata, hi, lo;

    muldiv_ex #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Instr_Ex(Instr_Ex), .Instr_ID(Instr_ID),
        .rsdata(rsdata), .rtdata(rtdata), .busy(busy), .stall_md(stall_md),
        .md_rdata(md_rdata), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        op_q[$];
    logic [31:0] rd_q[$];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_wr;
    int          m_left;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rins(input logic [5:0] fn);
        return {26'd0, fn};
    endfunction

    function automatic logic [5:0] fn_of(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) ? ins[5:0] : 6'h3F;
    endfunction

    function automatic bit is_st(input logic [31:0] ins);
        logic [5:0] f;
        f = fn_of(ins);
        return f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU;
    endfunction

    function automatic bit is_hl(input logic [31:0] ins);
        logic [5:0] f;
        f = fn_of(ins);
        return is_st(ins) || f == F_MFHI || f == F_MTHI || f == F_MFLO || f == F_MTLO;
    endfunction

    // One clock: drive inputs, model the edge, check the stall request mid-cycle.
    task automatic cyc(input logic [31:0] ex, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] id, input logic rst_n);
        logic [5:0] f;
        bit         st;
        longint     a, b;
        logic [63:0] r;
        exp_t       e;
        Instr_Ex = ex; rsdata = rs; rtdata = rt; Instr_ID = id; reset = rst_n;
        f  = fn_of(ex);
        st = is_st(ex) && m_left == 0;
        if (rst_n) begin
            if (f == F_MFHI) rd_q.push_back(m_hi);
            if (f == F_MFLO) rd_q.push_back(m_lo);
        end
        @(negedge clk);
        chk("stall_md", {31'd0, stall_md}, {31'd0, is_hl(id) && (m_left > 0 || st)});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_left = 0; m_hi = 0; m_lo = 0;
            op_q.delete();
            return;
        end
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (st) begin
            p_wr = 1'b1;
            if (f == F_MULT) begin
                a = longint'($signed(rs)); b = longint'($signed(rt)); r = 64'(a * b);
            end else if (f == F_MULTU) begin
                a = longint'(rs); b = longint'(rt); r = 64'(a * b);
            end else if (rt == 0) begin
                p_wr = 1'b0; r = {m_hi, m_lo};
            end else if (f == F_DIV) begin
                a = longint'($signed(rs)); b = longint'($signed(rt));
                r = {32'(a % b), 32'(a / b)};
            end else begin
                a = longint'(rs); b = longint'(rt);
                r = {32'(a % b), 32'(a / b)};
            end
            p_hi = r[63:32]; p_lo = r[31:0];
            m_left = (f == F_MULT || f == F_MULTU) ? MC : DC;
            e.hi = p_wr ? p_hi : m_hi;
            e.lo = p_wr ? p_lo : m_lo;
            e.n  = m_left;
            op_q.push_back(e);
        end else begin
            if (f == F_MTHI) m_hi = rs;
            if (f == F_MTLO) m_lo = rs;
        end
    endtask

    task automatic idle(input int n, input logic [31:0] id);
        for (int i = 0; i < n; i++) cyc(32'd0, 32'd0, 32'd0, id, 1'b1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (m_left > 0 && k < 40) begin
            idle(1, 32'd0);
            k++;
        end
        chk("drain_timeout", 32'(m_left), 32'd0);
    endtask

    // Monitor: completions on busy fall, read data on MFHI/MFLO in EX.
    initial begin
        automatic bit prev = 1'b0;
        automatic int len = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                prev = 1'b0; len = 0;
            end else begin
                if (busy) len++;
                if (prev && !busy) begin
                    if (op_q.size() == 0) begin
                        chk("op_q_empty", 32'd1, 32'd0);
                    end else begin
                        e = op_q.pop_front();
                        chk("busy_len", 32'(len), 32'(e.n));
                        chk("hi_done", hi, e.hi);
                        chk("lo_done", lo, e.lo);
                    end
                    len = 0;
                end
                prev = busy;
                if (fn_of(Instr_Ex) == F_MFHI || fn_of(Instr_Ex) == F_MFLO) begin
                    if (rd_q.size() == 0) chk("rd_q_empty", 32'd1, 32'd0);
                    else chk("md_rdata", md_rdata, rd_q.pop_front());
                end else begin
                    chk("md_rdata_zero", md_rdata, 32'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, ins;
        int          k;
        m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0; m_left = 0;

        // reset with a MULT sitting in EX
        cyc(rins(F_MULT), 32'd3, 32'd4, 32'd0, 1'b0);
        cyc(rins(F_MULT), 32'd3, 32'd4, 32'd0, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall_md}, 32'd0);

        // MULTU max*max with MFLO waiting in ID
        cyc(rins(F_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1);
        idle(MC, rins(F_MFLO));
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        cyc(rins(F_MFLO), 32'd0, 32'd0, 32'd0, 1'b1);

        // signed corners
        cyc(rins(F_MULT), -32'sd3, 32'd7, 32'd0, 1'b1);
        drain();
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        cyc(rins(F_DIV), -32'sd7, 32'd2, 32'd0, 1'b1);
        drain();
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        cyc(rins(F_DIV), 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1);
        drain();
        chk("divmin_lo", lo, 32'h80000000);
        chk("divmin_hi", hi, 32'd0);

        // divide by zero leaves preloaded HI/LO
        cyc(rins(F_MTHI), 32'h1234, 32'd0, 32'd0, 1'b1);
        cyc(rins(F_MTLO), 32'h5678, 32'd0, 32'd0, 1'b1);
        cyc(rins(F_DIVU), 32'd99, 32'd0, 32'd0, 1'b1);
        drain();
        chk("dz_hi", hi, 32'h1234);
        chk("dz_lo", lo, 32'h5678);

        // reset in the middle of a DIV; no late write afterwards
        cyc(rins(F_DIV), 32'd100, 32'd7, 32'd0, 1'b1);
        idle(3, 32'd0);
        cyc(32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        idle(DC, 32'd0);
        chk("mid_hi", hi, 32'd0);
        chk("mid_lo", lo, 32'd0);

        // second MULT and an MTLO while busy are both ignored
        cyc(rins(F_MULT), 32'd2, 32'd3, 32'd0, 1'b1);
        cyc(rins(F_MULT), 32'd5, 32'd5, 32'd0, 1'b1);
        cyc(rins(F_MTLO), 32'd99, 32'd0, 32'd0, 1'b1);
        drain();
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd6);

        // MTHI then MFHI
        cyc(rins(F_MTHI), 32'hAAAA, 32'd0, 32'd0, 1'b1);
        Instr_Ex = rins(F_MFHI);
        #1;
        chk("mfhi_direct", md_rdata, 32'hAAAA);
        cyc(rins(F_MFHI), 32'd0, 32'd0, 32'd0, 1'b1);

        // random traffic, including ops issued while busy and non-SPECIAL words
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 11);
            case (k)
                0: ins = rins(F_MULT);
                1: ins = rins(F_MULTU);
                2: ins = rins(F_DIV);
                3: ins = rins(F_DIVU);
                4: ins = rins(F_MTHI);
                5: ins = rins(F_MTLO);
                6: ins = rins(F_MFHI);
                7: ins = rins(F_MFLO);
                8: ins = {6'h23, 20'd0, F_MULT};
                9: ins = {6'h01, 20'd0, F_MTHI};
                default: ins = 32'd0;
            endcase
            a = $urandom();
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom();
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            cyc(ins, a, b, rins(6'($urandom_range(16, 27))), 1'b1);
        end
        drain();
        idle(2, 32'd0);
        chk("final_hi", hi, m_hi);
        chk("final_lo", lo, m_lo);
        chk("op_q_left", 32'(op_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
